// File: rtl/vga_rect_filler_if.sv
// Command, status and video-RAM write port of the rectangle fill engine.
// master = command issuer / RAM side, slave = vga_rect_filler.
interface vga_rect_filler_if #(
  parameter int ADDR_WIDTH  = 19,
  parameter int COLOR_WIDTH = 3
);
  logic                   iStart;
  logic [8:0]             iX;
  logic [7:0]             iY;
  logic [8:0]             iWidth;
  logic [7:0]             iHeight;
  logic [COLOR_WIDTH-1:0] iColor;
  logic                   iStall;
  logic                   oBusy;
  logic                   oDone;
  logic                   oError;
  logic                   oWriteEnable;
  logic [ADDR_WIDTH-1:0]  oWriteAddress;
  logic [COLOR_WIDTH-1:0] oDataOut;

  modport master (
    output iStart, iX, iY, iWidth, iHeight, iColor, iStall,
    input  oBusy, oDone, oError,
    input  oWriteEnable, oWriteAddress, oDataOut
  );

  modport slave (
    input  iStart, iX, iY, iWidth, iHeight, iColor, iStall,
    output oBusy, oDone, oError,
    output oWriteEnable, oWriteAddress, oDataOut
  );
endinterface

// File: rtl/vga_rect_filler.sv
// Solid-colour rectangle fill engine, writer side of the 400x240 framebuffer.
// Define RECT_FILL_CLIP_EN to clip to the screen instead of rejecting.
module vga_rect_filler #(
  parameter int FB_WIDTH    = 400,
  parameter int FB_HEIGHT   = 240,
  parameter int ADDR_WIDTH  = 19,
  parameter int COLOR_WIDTH = 3
) (
  input logic Clock,
  input logic Reset,
  vga_rect_filler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE, S_CHECK, S_FILL, S_DONE
  } state_t;

  localparam logic [9:0] LP_FBW = 10'(FB_WIDTH);
  localparam logic [8:0] LP_FBH = 9'(FB_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] LP_STRIDE =
    ADDR_WIDTH'(FB_WIDTH);

  state_t                 r_state, w_state;
  logic [8:0]             r_x, w_x;
  logic [7:0]             r_y, w_y;
  logic [8:0]             r_w, w_w;
  logic [7:0]             r_h, w_h;
  logic [COLOR_WIDTH-1:0] r_color, w_color;
  logic [8:0]             r_effW, w_effW;
  logic [7:0]             r_effH, w_effH;
  logic [8:0]             r_col, w_col;
  logic [7:0]             r_row, w_row;
  logic [ADDR_WIDTH-1:0]  r_rowBase, w_rowBase;
  logic                   r_busy, w_busy;
  logic                   r_done, w_done;
  logic                   r_error, w_error;
  logic                   r_we, w_we;
  logic [ADDR_WIDTH-1:0]  r_addr, w_addr;
  logic [COLOR_WIDTH-1:0] r_data, w_data;

  logic [8:0]             w_cW;
  logic [7:0]             w_cH;
  logic                   w_reject;

`ifdef RECT_FILL_CLIP_EN
  logic [8:0] w_xRoom;
  logic [7:0] w_yRoom;

  // Clip the latched rectangle to the visible area.
  always_comb begin
    w_xRoom = ({1'b0, r_x} >= LP_FBW) ? 9'd0
            : 9'(LP_FBW - {1'b0, r_x});
    w_yRoom = ({1'b0, r_y} >= LP_FBH) ? 8'd0
            : 8'(LP_FBH - {1'b0, r_y});
    w_cW = (r_w < w_xRoom) ? r_w : w_xRoom;
    w_cH = (r_h < w_yRoom) ? r_h : w_yRoom;
    w_reject = 1'b0;
  end
`else
  logic [9:0] w_xEnd;
  logic [8:0] w_yEnd;

  // Reject any rectangle that leaves the visible area.
  always_comb begin
    w_xEnd = {1'b0, r_x} + {1'b0, r_w};
    w_yEnd = {1'b0, r_y} + {1'b0, r_h};
    w_cW = r_w;
    w_cH = r_h;
    w_reject = ({1'b0, r_x} >= LP_FBW) |
               ({1'b0, r_y} >= LP_FBH) |
               (w_xEnd > LP_FBW) |
               (w_yEnd > LP_FBH);
  end
`endif

  // State register.
  always_ff @(posedge Clock) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state;
  end

  // Next state, counters and registered outputs.
  always_comb begin
    w_state   = r_state;
    w_x       = r_x;
    w_y       = r_y;
    w_w       = r_w;
    w_h       = r_h;
    w_color   = r_color;
    w_effW    = r_effW;
    w_effH    = r_effH;
    w_col     = r_col;
    w_row     = r_row;
    w_rowBase = r_rowBase;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_error   = 1'b0;
    w_we      = 1'b0;
    w_addr    = r_addr;
    w_data    = r_data;
    unique case (r_state)
      S_IDLE: begin
        if (bus.iStart) begin
          w_x     = bus.iX;
          w_y     = bus.iY;
          w_w     = bus.iWidth;
          w_h     = bus.iHeight;
          w_color = bus.iColor;
          w_busy  = 1'b1;
          w_state = S_CHECK;
        end
      end
      S_CHECK: begin
        w_col     = 9'd0;
        w_row     = 8'd0;
        w_effW    = w_cW;
        w_effH    = w_cH;
        w_rowBase = ADDR_WIDTH'(r_y) * LP_STRIDE;
        if (w_reject) begin
          w_error = 1'b1;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end else if (w_cW == 9'd0 || w_cH == 8'd0) begin
          w_state = S_DONE;
        end else begin
          w_state = S_FILL;
        end
      end
      S_FILL: begin
        if (!bus.iStall) begin
          w_we   = 1'b1;
          w_data = r_color;
          w_addr = r_rowBase + ADDR_WIDTH'(r_x)
                 + ADDR_WIDTH'(r_col);
          if (r_col == r_effW - 9'd1) begin
            w_col = 9'd0;
            if (r_row == r_effH - 8'd1) begin
              w_state = S_DONE;
            end else begin
              w_row     = r_row + 8'd1;
              w_rowBase = r_rowBase + LP_STRIDE;
            end
          end else begin
            w_col = r_col + 9'd1;
          end
        end
      end
      S_DONE: begin
        w_done  = 1'b1;
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  // Datapath and output registers; reset aborts any fill.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_x       <= '0;
      r_y       <= '0;
      r_w       <= '0;
      r_h       <= '0;
      r_color   <= '0;
      r_effW    <= '0;
      r_effH    <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_rowBase <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      r_x       <= w_x;
      r_y       <= w_y;
      r_w       <= w_w;
      r_h       <= w_h;
      r_color   <= w_color;
      r_effW    <= w_effW;
      r_effH    <= w_effH;
      r_col     <= w_col;
      r_row     <= w_row;
      r_rowBase <= w_rowBase;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_error   <= w_error;
      r_we      <= w_we;
      r_addr    <= w_addr;
      r_data    <= w_data;
    end
  end

  assign bus.oBusy         = r_busy;
  assign bus.oDone         = r_done;
  assign bus.oError        = r_error;
  assign bus.oWriteEnable  = r_we;
  assign bus.oWriteAddress = r_addr;
  assign bus.oDataOut      = r_data;

endmodule

// File: tb/tb_vga_rect_filler.sv
// Directed bench for vga_rect_filler: fill commands, stall,
// empty/oversized rectangles, busy-drop and mid-fill reset.
module tb_vga_rect_filler;

  logic Clock = 1'b0;
  logic Reset;

  always #5 Clock = ~Clock;

  vga_rect_filler_if #(.ADDR_WIDTH(19), .COLOR_WIDTH(3)) bus ();

  vga_rect_filler #(
    .FB_WIDTH(400), .FB_HEIGHT(240),
    .ADDR_WIDTH(19), .COLOR_WIDTH(3)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wa[$];
  int wd[$];
  int wc[$];
  int done_cnt, done_cyc, err_cnt, busy_cnt;

  always @(posedge Clock) begin
    cyc++;
    #1;
    if (bus.oWriteEnable) begin
      wa.push_back(int'(bus.oWriteAddress));
      wd.push_back(int'(bus.oDataOut));
      wc.push_back(cyc);
    end
    if (bus.oDone) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.oError) err_cnt++;
    if (bus.oBusy)  busy_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    wa.delete();
    wd.delete();
    wc.delete();
    done_cnt = 0;
    done_cyc = -1;
    err_cnt  = 0;
    busy_cnt = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #2;
    end
  endtask

  task automatic start(input int x, input int y, input int w,
                       input int h, input int c, output int sc);
    bus.iX      = 9'(x);
    bus.iY      = 8'(y);
    bus.iWidth  = 9'(w);
    bus.iHeight = 8'(h);
    bus.iColor  = 3'(c);
    bus.iStart  = 1'b1;
    @(posedge Clock);
    #2;
    sc = cyc;
    bus.iStart = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int lim);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (done_cnt > 0 || err_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    check({tag, "_end"}, int'(ok), 1);
    step(2);
  endtask

  task automatic chk_writes(input string tag, input int ea[$],
                            input int ed);
    int ga, gd;
    check({tag, "_nwr"}, wa.size(), ea.size());
    for (int i = 0; i < ea.size(); i++) begin
      ga = (i < wa.size()) ? wa[i] : -1;
      gd = (i < wd.size()) ? wd[i] : -1;
      check({tag, "_addr"}, ga, ea[i]);
      check({tag, "_data"}, gd, ed);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    check({tag, "_we"},   int'(bus.oWriteEnable), 0);
    check({tag, "_busy"}, int'(bus.oBusy), 0);
    check({tag, "_done"}, int'(bus.oDone), 0);
    check({tag, "_err"},  int'(bus.oError), 0);
    check({tag, "_addr"}, int'(bus.oWriteAddress), 0);
    check({tag, "_data"}, int'(bus.oDataOut), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sc;
    int n;
    int last;
    int eq[$];

    Reset       = 1'b0;
    bus.iStart  = 1'b0;
    bus.iX      = '0;
    bus.iY      = '0;
    bus.iWidth  = '0;
    bus.iHeight = '0;
    bus.iColor  = '0;
    bus.iStall  = 1'b0;
    step(3);
    chk_idle_outs("rst");
    Reset = 1'b1;
    step(1);

    // basic 3x2 fill
    clr();
    start(10, 5, 3, 2, 5, sc);
    wait_end("basic", 40);
    eq = '{2010, 2011, 2012, 2410, 2411, 2412};
    chk_writes("basic", eq, 5);
    check("basic_lat", (wc.size() > 0) ? wc[0] - sc : -1, 2);
    last = (wc.size() > 0) ? wc[wc.size()-1] : -100;
    check("basic_donelat", done_cyc - last, 1);
    check("basic_ndone", done_cnt, 1);
    check("basic_nerr", err_cnt, 0);

    // same fill with four stalled cycles after the 2nd write
    clr();
    start(10, 5, 3, 2, 5, sc);
    for (int i = 0; i < 20; i++) begin
      if (wa.size() >= 2) break;
      step(1);
    end
    check("stall_pre", wa.size(), 2);
    bus.iStall = 1'b1;
    step(4);
    bus.iStall = 1'b0;
    wait_end("stall", 40);
    chk_writes("stall", eq, 5);
    last = (wc.size() > 0) ? wc[wc.size()-1] - wc[0] + 1 : -1;
    check("stall_span", last, 10);
    check("stall_ndone", done_cnt, 1);

    // zero width: no writes, done two cycles after start
    clr();
    start(10, 5, 0, 7, 1, sc);
    wait_end("zero", 20);
    check("zero_nwr", wa.size(), 0);
    check("zero_donelat", done_cyc - sc, 2);
    check("zero_busy", busy_cnt, 2);
    check("zero_ndone", done_cnt, 1);

    // rectangle hanging off the bottom-right corner
    clr();
    start(398, 239, 5, 3, 6, sc);
    wait_end("edge", 40);
`ifdef RECT_FILL_CLIP_EN
    eq = '{95998, 95999};
    chk_writes("edge", eq, 6);
    check("edge_ndone", done_cnt, 1);
    check("edge_nerr", err_cnt, 0);
`else
    check("edge_nwr", wa.size(), 0);
    check("edge_ndone", done_cnt, 0);
    check("edge_nerr", err_cnt, 1);
    check("edge_busy", busy_cnt, 1);
`endif

    // second start while filling is dropped
    clr();
    start(0, 0, 4, 1, 2, sc);
    step(1);
    bus.iX     = 9'd100;
    bus.iStart = 1'b1;
    step(1);
    bus.iStart = 1'b0;
    wait_end("drop", 40);
    step(6);
    eq = '{0, 1, 2, 3};
    chk_writes("drop", eq, 2);
    check("drop_ndone", done_cnt, 1);

    // reset in the middle of a full-screen fill
    clr();
    start(0, 0, 400, 240, 7, sc);
    step(20);
    Reset = 1'b0;
    step(1);
    chk_idle_outs("midrst");
    n = wa.size();
    check("midrst_nwr", n, 19);
    step(2);
    Reset = 1'b1;
    step(5);
    check("midrst_after", wa.size(), n);
    check("midrst_ndone", done_cnt, 0);

    // block accepts a command after the reset
    clr();
    start(10, 5, 3, 2, 5, sc);
    wait_end("postrst", 40);
    eq = '{2010, 2011, 2012, 2410, 2411, 2412};
    chk_writes("postrst", eq, 5);
    check("postrst_ndone", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
